// File: rtl/game_pkg.sv
// Shared game definitions: player life FSM encoding, lives width and default frame timings.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    DYING     = 3'd2,
    INVULN    = 3'd3,
    GAME_OVER = 3'd4
  } life_state_t;

  localparam int LIVES_W           = 3;
  localparam int DEF_INIT_LIVES    = 3;
  localparam int DEF_DEATH_FRAMES  = 30;
  localparam int DEF_INVULN_FRAMES = 60;
  localparam int DEF_BLINK_FRAMES  = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..v inclusive.
  function automatic int bits_for(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/player_life_manager_frame_timer.sv
// Frame-granular down counter: loads on demand, decrements once per startOfFrame, saturates at 0.
module frame_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         startOfFrame,
  output logic [W-1:0] count,
  output logic         last_frame
);

  logic [W-1:0] count_r;

  // Counter register; a load in the same cycle as startOfFrame takes priority over the decrement.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (startOfFrame && (count_r != W'(0))) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count      = count_r;
  assign last_frame = startOfFrame && (count_r == W'(1));

endmodule

// File: rtl/player_life_manager.sv
// Player life FSM: turns collision pulses into lives, death freeze, blinking invulnerability and game over.
module player_life_manager
  import game_pkg::*;
#(
  parameter int INIT_LIVES    = DEF_INIT_LIVES,
  parameter int DEATH_FRAMES  = DEF_DEATH_FRAMES,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int BLINK_FRAMES  = DEF_BLINK_FRAMES
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               hit_blast,
  input  logic               hit_enemy,
  input  logic               start_game,
  output logic [LIVES_W-1:0] lives,
  output logic               life_lost,
  output logic               player_freeze,
  output logic               player_visible,
  output logic               game_over,
  output logic [2:0]         game_state
);

  localparam int TIMER_W = bits_for(max_int(DEATH_FRAMES, INVULN_FRAMES));
  localparam int BLINK_W = bits_for(BLINK_FRAMES);

  life_state_t        state_r, state_n_s;
  logic [LIVES_W-1:0] lives_r, lives_n_s;
  logic               life_lost_r, life_lost_n_s;
  logic               freeze_r, freeze_n_s;
  logic               visible_r, visible_n_s;
  logic               game_over_r, game_over_n_s;
  logic [BLINK_W-1:0] blink_r, blink_n_s, blink_inc_s;

  logic               hit_s;
  logic               timer_load_s;
  logic [TIMER_W-1:0] timer_load_val_s;
  logic [TIMER_W-1:0] timer_count_s;
  logic               timer_last_s;

  assign hit_s       = hit_blast | hit_enemy;
  assign blink_inc_s = blink_r + BLINK_W'(1);

  frame_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk         (clk),
    .resetN      (resetN),
    .load        (timer_load_s),
    .load_val    (timer_load_val_s),
    .startOfFrame(startOfFrame),
    .count       (timer_count_s),
    .last_frame  (timer_last_s)
  );

  // State, lives, blink counter and output flags are all registered together.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r     <= IDLE;
      lives_r     <= '0;
      life_lost_r <= 1'b0;
      freeze_r    <= 1'b1;
      visible_r   <= 1'b0;
      game_over_r <= 1'b0;
      blink_r     <= '0;
    end else begin
      state_r     <= state_n_s;
      lives_r     <= lives_n_s;
      life_lost_r <= life_lost_n_s;
      freeze_r    <= freeze_n_s;
      visible_r   <= visible_n_s;
      game_over_r <= game_over_n_s;
      blink_r     <= blink_n_s;
    end
  end

  // Next state plus the flag values that belong to the state being entered.
  always_comb begin
    state_n_s        = state_r;
    lives_n_s        = lives_r;
    life_lost_n_s    = 1'b0;
    freeze_n_s       = freeze_r;
    visible_n_s      = visible_r;
    game_over_n_s    = 1'b0;
    blink_n_s        = blink_r;
    timer_load_s     = 1'b0;
    timer_load_val_s = '0;

    case (state_r)
      IDLE, GAME_OVER: begin
        if (start_game) begin
          state_n_s   = PLAY;
          lives_n_s   = LIVES_W'(INIT_LIVES);
          freeze_n_s  = 1'b0;
          visible_n_s = 1'b1;
        end else begin
          lives_n_s     = (state_r == GAME_OVER) ? LIVES_W'(0) : lives_r;
          freeze_n_s    = 1'b1;
          visible_n_s   = 1'b0;
          game_over_n_s = (state_r == GAME_OVER);
        end
      end

      PLAY: begin
        if (hit_s) begin
          life_lost_n_s = 1'b1;
          lives_n_s     = lives_r - LIVES_W'(1);
          freeze_n_s    = 1'b1;
          if (lives_r == LIVES_W'(1)) begin
            state_n_s     = GAME_OVER;
            visible_n_s   = 1'b0;
            game_over_n_s = 1'b1;
          end else begin
            state_n_s        = DYING;
            visible_n_s      = 1'b1;
            timer_load_s     = 1'b1;
            timer_load_val_s = TIMER_W'(DEATH_FRAMES);
          end
        end else begin
          freeze_n_s  = 1'b0;
          visible_n_s = 1'b1;
        end
      end

      DYING: begin
        if (timer_last_s) begin
          state_n_s        = INVULN;
          timer_load_s     = 1'b1;
          timer_load_val_s = TIMER_W'(INVULN_FRAMES);
          blink_n_s        = '0;
          freeze_n_s       = 1'b0;
          visible_n_s      = 1'b0;
        end else begin
          freeze_n_s  = 1'b1;
          visible_n_s = 1'b1;
        end
      end

      INVULN: begin
        freeze_n_s = 1'b0;
        if (timer_last_s) begin
          state_n_s   = PLAY;
          visible_n_s = 1'b1;
        end else if (startOfFrame) begin
          if (blink_inc_s == BLINK_W'(BLINK_FRAMES)) begin
            blink_n_s   = '0;
            visible_n_s = ~visible_r;
          end else begin
            blink_n_s = blink_inc_s;
          end
        end else begin
          visible_n_s = visible_r;
        end
      end

      default: begin
        state_n_s   = IDLE;
        lives_n_s   = '0;
        freeze_n_s  = 1'b1;
        visible_n_s = 1'b0;
        blink_n_s   = '0;
      end
    endcase
  end

  assign lives          = lives_r;
  assign life_lost      = life_lost_r;
  assign player_freeze  = freeze_r;
  assign player_visible = visible_r;
  assign game_over      = game_over_r;
  assign game_state     = state_r;

endmodule

// File: tb/tb_player_life_manager.sv
// Scoreboard bench for player_life_manager with short frame timings.
module tb_player_life_manager;
  import game_pkg::*;

  localparam int D_FR = 3;
  localparam int I_FR = 4;
  localparam int B_FR = 2;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] lv;
    logic       ll;
    logic       fr;
    logic       vis;
    logic       go;
  } obs_t;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       hit_blast = 1'b0;
  logic       hit_enemy = 1'b0;
  logic       start_game = 1'b0;
  logic [2:0] lives;
  logic       life_lost;
  logic       player_freeze;
  logic       player_visible;
  logic       game_over;
  logic [2:0] game_state;

  int   tests = 0;
  int   fails = 0;
  obs_t sb_q[$];

  player_life_manager #(
    .INIT_LIVES   (3),
    .DEATH_FRAMES (D_FR),
    .INVULN_FRAMES(I_FR),
    .BLINK_FRAMES (B_FR)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .hit_blast     (hit_blast),
    .hit_enemy     (hit_enemy),
    .start_game    (start_game),
    .lives         (lives),
    .life_lost     (life_lost),
    .player_freeze (player_freeze),
    .player_visible(player_visible),
    .game_over     (game_over),
    .game_state    (game_state)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [2:0] st, input logic [2:0] lv, input logic ll,
                              input logic fr, input logic vis, input logic go);
    return {st, lv, ll, fr, vis, go};
  endfunction

  function automatic obs_t observe();
    return {game_state, lives, life_lost, player_freeze, player_visible, game_over};
  endfunction

  // Visibility after i invulnerable frames: starts hidden, flips every B_FR frames.
  function automatic logic inv_vis(input int i);
    return ((i / B_FR) % 2) == 1;
  endfunction

  task automatic drive(input logic sof, input logic hb, input logic he, input logic sg);
    startOfFrame = sof;
    hit_blast    = hb;
    hit_enemy    = he;
    start_game   = sg;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    hit_blast    = 1'b0;
    hit_enemy    = 1'b0;
    start_game   = 1'b0;
  endtask

  task automatic test_reset();
    obs_t exp, got;
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb_q.push_back(mk(IDLE, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    exp = sb_q.pop_front(); got = observe(); tests++;
    if (got !== exp) begin fails++; $display("FAIL reset_values: got %h required %h", got, exp); end
    tests++;
    if (dut.timer_count_s !== 3'd0) begin fails++; $display("FAIL reset_timer: got %0d required 0", dut.timer_count_s); end
    resetN = 1'b1;
    sb_q.push_back(mk(IDLE, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp = sb_q.pop_front(); got = observe(); tests++;
    if (got !== exp) begin fails++; $display("FAIL idle_hold: got %h required %h", got, exp); end
  endtask

  task automatic test_start();
    obs_t exp, got;
    sb_q.push_back(mk(PLAY, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0));
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    exp = sb_q.pop_front(); got = observe(); tests++;
    if (got !== exp) begin fails++; $display("FAIL start_game: got %h required %h", got, exp); end
  endtask

  // Walks DYING and INVULN with hits injected between frames; lives must stay at lv.
  task automatic recover(input logic [2:0] lv);
    obs_t exp, got;
    for (int f = 1; f <= D_FR; f++) begin
      sb_q.push_back(mk(DYING, lv, 1'b0, 1'b1, 1'b1, 1'b0));
      drive(1'b0, 1'b1, (f == 2), 1'b0);
      exp = sb_q.pop_front(); got = observe(); tests++;
      if (got !== exp) begin fails++; $display("FAIL dying_hit f%0d: got %h required %h", f, got, exp); end
      if (f < D_FR) sb_q.push_back(mk(DYING, lv, 1'b0, 1'b1, 1'b1, 1'b0));
      else          sb_q.push_back(mk(INVULN, lv, 1'b0, 1'b0, 1'b0, 1'b0));
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      exp = sb_q.pop_front(); got = observe(); tests++;
      if (got !== exp) begin fails++; $display("FAIL dying_frame f%0d: got %h required %h", f, got, exp); end
    end
    for (int f = 1; f <= I_FR; f++) begin
      sb_q.push_back(mk(INVULN, lv, 1'b0, 1'b0, inv_vis(f - 1), 1'b0));
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      exp = sb_q.pop_front(); got = observe(); tests++;
      if (got !== exp) begin fails++; $display("FAIL invuln_hit f%0d: got %h required %h", f, got, exp); end
      if (f < I_FR) sb_q.push_back(mk(INVULN, lv, 1'b0, 1'b0, inv_vis(f), 1'b0));
      else          sb_q.push_back(mk(PLAY, lv, 1'b0, 1'b0, 1'b1, 1'b0));
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      exp = sb_q.pop_front(); got = observe(); tests++;
      if (got !== exp) begin fails++; $display("FAIL invuln_frame f%0d: got %h required %h", f, got, exp); end
    end
  endtask

  task automatic test_hit_cycle();
    obs_t exp, got;
    sb_q.push_back(mk(DYING, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0));
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    exp = sb_q.pop_front(); got = observe(); tests++;
    if (got !== exp) begin fails++; $display("FAIL hit_blast: got %h required %h", got, exp); end
    recover(3'd2);
  endtask

  task automatic test_double_hit();
    obs_t exp, got;
    sb_q.push_back(mk(DYING, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0));
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    exp = sb_q.pop_front(); got = observe(); tests++;
    if (got !== exp) begin fails++; $display("FAIL double_hit: got %h required %h", got, exp); end
    recover(3'd1);
  endtask

  task automatic test_restart_conflict();
    obs_t exp, got;
    sb_q.push_back(mk(GAME_OVER, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1));
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    exp = sb_q.pop_front(); got = observe(); tests++;
    if (got !== exp) begin fails++; $display("FAIL last_life: got %h required %h", got, exp); end
    sb_q.push_back(mk(GAME_OVER, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1));
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp = sb_q.pop_front(); got = observe(); tests++;
    if (got !== exp) begin fails++; $display("FAIL game_over_hold: got %h required %h", got, exp); end
    sb_q.push_back(mk(PLAY, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0));
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    exp = sb_q.pop_front(); got = observe(); tests++;
    if (got !== exp) begin fails++; $display("FAIL restart_vs_hit: got %h required %h", got, exp); end
  endtask

  task automatic test_three_hits();
    obs_t exp, got;
    for (int h = 1; h <= 3; h++) begin
      if (h < 3) sb_q.push_back(mk(DYING, 3'(3 - h), 1'b1, 1'b1, 1'b1, 1'b0));
      else       sb_q.push_back(mk(GAME_OVER, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1));
      drive(1'b0, (h != 2), (h == 2), 1'b0);
      exp = sb_q.pop_front(); got = observe(); tests++;
      if (got !== exp) begin fails++; $display("FAIL spaced_hit%0d: got %h required %h", h, got, exp); end
      if (h < 3) recover(3'(3 - h));
    end
    sb_q.push_back(mk(PLAY, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0));
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    exp = sb_q.pop_front(); got = observe(); tests++;
    if (got !== exp) begin fails++; $display("FAIL restart: got %h required %h", got, exp); end
  endtask

  task automatic test_hit_sof();
    obs_t exp, got;
    sb_q.push_back(mk(PLAY, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0));
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    exp = sb_q.pop_front(); got = observe(); tests++;
    if (got !== exp) begin fails++; $display("FAIL start_in_play: got %h required %h", got, exp); end
    sb_q.push_back(mk(DYING, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0));
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp = sb_q.pop_front(); got = observe(); tests++;
    if (got !== exp) begin fails++; $display("FAIL hit_with_sof: got %h required %h", got, exp); end
    tests++;
    if (dut.timer_count_s !== 3'd3) begin fails++; $display("FAIL timer_load: got %0d required 3", dut.timer_count_s); end
    sb_q.push_back(mk(DYING, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0));
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    exp = sb_q.pop_front(); got = observe(); tests++;
    if (got !== exp) begin fails++; $display("FAIL start_in_dying: got %h required %h", got, exp); end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tests++;
    if (dut.timer_count_s !== 3'd2) begin fails++; $display("FAIL timer_dec: got %0d required 2", dut.timer_count_s); end
  endtask

  task automatic test_reset_mid();
    obs_t exp, got;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    sb_q.push_back(mk(INVULN, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    exp = sb_q.pop_front(); got = observe(); tests++;
    if (got !== exp) begin fails++; $display("FAIL enter_invuln: got %h required %h", got, exp); end
    #2 resetN = 1'b0;
    #1;
    sb_q.push_back(mk(IDLE, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    exp = sb_q.pop_front(); got = observe(); tests++;
    if (got !== exp) begin fails++; $display("FAIL async_reset: got %h required %h", got, exp); end
    tests++;
    if (dut.timer_count_s !== 3'd0) begin fails++; $display("FAIL async_reset_timer: got %0d required 0", dut.timer_count_s); end
    @(posedge clk);
    #3 resetN = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      sb_q.push_back(mk(IDLE, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      exp = sb_q.pop_front(); got = observe(); tests++;
      if (got !== exp) begin fails++; $display("FAIL post_reset_idle%0d: got %h required %h", c, got, exp); end
    end
    sb_q.push_back(mk(PLAY, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0));
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    exp = sb_q.pop_front(); got = observe(); tests++;
    if (got !== exp) begin fails++; $display("FAIL post_reset_start: got %h required %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit_cycle();
    test_double_hit();
    test_restart_conflict();
    test_three_hits();
    test_hit_sof();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
